bg7_fetch_seq: RTL

Per-dot fetch sequencer for the BG Mode 7 pipeline. It consumes the four signed Mode 7 matrix products produced by the shared multiplier stage in dot phases 0–1. From those it forms the 10-bit playfield coordinates, applies the out-of-bounds policy, and schedules the two VRAM reads (tilemap byte on the low plane, character byte on the high plane) inside one 8-clock dot. It publishes one registered pixel per dot to the BG compositor.

---
 rtl/bg7_fetch_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bg7_fetch_seq.sv
// Mode 7 per-dot fetch sequencer: turns the four matrix products into
// playfield coordinates, schedules tilemap and character VRAM reads
// inside one 8-clock dot and publishes one registered pixel per dot.
module bg7_fetch_seq (
  input  logic               clk,
  input  logic               reset,
  input  logic               dot_en,
  input  logic [2:0]         dot_ctr,
  input  logic               enable,
  input  logic [3:0]         m7sel,
  input  logic signed [12:0] m7_xorig,
  input  logic signed [12:0] m7_yorig,
  input  logic signed [27:0] prod_ax,
  input  logic signed [27:0] prod_by,
  input  logic signed [27:0] prod_cx,
  input  logic signed [27:0] prod_dy,
  output logic [14:0]        vram_l_addr,
  output logic [14:0]        vram_h_addr,
  input  logic [7:0]         vram_rdata_l,
  input  logic [7:0]         vram_rdata_h,
  output logic [7:0]         pix_color,
  output logic               pix_opaque,
  output logic               pix_oob
);

  // Two products summed at 29 bits, dropped to integer pixels, then offset
  // by the centre; the result deliberately wraps modulo 2^21.
  function automatic logic signed [20:0] m7_coord(
    input logic signed [27:0] p0,
    input logic signed [27:0] p1,
    input logic signed [12:0] orig
  );
    logic signed [28:0] sum;
    logic signed [28:0] shifted;
    logic        [20:0] ext_orig;
    sum      = {p0[27], p0} + {p1[27], p1};
    shifted  = sum >>> 8;
    ext_orig = {{8{orig[12]}}, orig};
    return shifted[20:0] + ext_orig;
  endfunction

  // Any bit above the 1024-pixel playfield means the coordinate is outside.
  function automatic logic out_of_range(input logic signed [20:0] c);
    return c[20:10] != 11'd0;
  endfunction

  logic signed [20:0] vx_n;
  logic signed [20:0] vy_n;
  logic               oob_n;

  logic signed [20:0] vx;
  logic signed [20:0] vy;
  logic               oob;
  logic [7:0]         tile;
  logic [7:0]         color;
  logic               st_a;
  logic               st_t;
  logic               st_c;
  logic               st_p;
  logic               over_transp;
  logic               over_tile0;

  assign vx_n  = m7_coord(prod_ax, prod_by, m7_xorig);
  assign vy_n  = m7_coord(prod_cx, prod_dy, m7_yorig);
  assign oob_n = out_of_range(vx_n) || out_of_range(vy_n);

  // Screen-over policy decoded from the latched out-of-bounds flag.
  assign over_transp = oob && (m7sel[3:2] == 2'b10);
  assign over_tile0  = oob && (m7sel[3:2] == 2'b11);

  // Phase-scheduled fetch pipeline; each stage only advances when the
  // previous stage ran in this same dot, so a broken sequence publishes
  // a transparent pixel instead of stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vx          <= '0;
      vy          <= '0;
      oob         <= 1'b0;
      tile        <= '0;
      color       <= '0;
      st_a        <= 1'b0;
      st_t        <= 1'b0;
      st_c        <= 1'b0;
      st_p        <= 1'b0;
      vram_l_addr <= '0;
      vram_h_addr <= '0;
      pix_color   <= '0;
      pix_opaque  <= 1'b0;
      pix_oob     <= 1'b0;
    end else begin
      case (dot_ctr)
        // ph0: start of dot, forget everything from the previous one
        3'd0: begin
          st_a <= 1'b0;
          st_t <= 1'b0;
          st_c <= 1'b0;
          st_p <= 1'b0;
        end
        // ph2: coordinates ready, issue the tilemap read
        3'd2: begin
          vx   <= vx_n;
          vy   <= vy_n;
          oob  <= oob_n;
          st_a <= 1'b1;
          if (enable) vram_l_addr <= {1'b0, vy_n[9:3], vx_n[9:3]};
        end
        // ph3: tilemap byte arrives
        3'd3: begin
          if (st_a) begin
            tile <= over_tile0 ? 8'h00 : vram_rdata_l;
            st_t <= 1'b1;
          end
        end
        // ph4: issue the character read for the pixel inside the tile
        3'd4: begin
          if (st_t) begin
            if (enable) vram_h_addr <= {1'b0, tile, vy[2:0], vx[2:0]};
            st_c <= 1'b1;
          end
        end
        // ph5: character byte arrives
        3'd5: begin
          if (st_c) begin
            color <= vram_rdata_h;
            st_p  <= 1'b1;
          end
        end
        // ph7: publish to the compositor on the dot strobe
        3'd7: begin
          if (dot_en) begin
            pix_color  <= (st_p && !over_transp) ? color : 8'h00;
            pix_oob    <= st_p && oob;
            pix_opaque <= st_p && enable && (color != 8'h00) && !over_transp;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
